// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: default datapath widths, ALU operation
// encodings and the branch-condition rule used by the EX/MEM boundary.
package riscv_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int RADDR_W_DEFAULT = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_XOR = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SLL = 4'b0101
  } aluOp_e;

  // beq is taken when the ALU saw equality (zero), bne when it did not.
  function automatic logic branchCondition(input logic isBranch,
                                           input logic isBne,
                                           input logic zero);
    return isBranch && (zero ^ isBne);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution: taken decision and target address.
// Target wraps modulo 2^XLEN.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            branch,
  input  logic            branchNe,
  input  logic            zero,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  assign taken  = branchCondition(branch, branchNe, zero);
  assign target = pc + imm;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM single-entry pipeline register with valid/ready handshake and flush.
// Branch resolution is registered only when EX_MEM_BRANCH_EN is defined.
module ex_mem_reg
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [XLEN-1:0]    aluResultIn,
  input  logic               zeroIn,
  input  logic [XLEN-1:0]    storeDataIn,
  input  logic [RADDR_W-1:0] rdIn,
  input  logic               regWriteIn,
  input  logic               memReadIn,
  input  logic               memWriteIn,
  input  logic               branchIn,
  input  logic               branchNeIn,
  input  logic [XLEN-1:0]    pcIn,
  input  logic [XLEN-1:0]    immIn,
  input  logic               flush,
  output logic               outValid,
  input  logic               outReady,
  output logic [XLEN-1:0]    aluResultOut,
  output logic [XLEN-1:0]    storeDataOut,
  output logic [RADDR_W-1:0] rdOut,
  output logic               regWriteOut,
  output logic               memReadOut,
  output logic               memWriteOut,
  output logic               branchTaken,
  output logic [XLEN-1:0]    branchTarget
);

  logic capture;
  logic regWriteQ;
  logic memReadQ;
  logic memWriteQ;

  assign inReady = !outValid || outReady;
  assign capture = inValid && inReady && !flush;

  // Flush wins over capture; a drain with a simultaneous capture keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (capture) begin
      outValid <= 1'b1;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

  // x0 writes and read+write conflicts are sanitised once, at capture time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluResultOut <= '0;
      storeDataOut <= '0;
      rdOut        <= '0;
      regWriteQ    <= 1'b0;
      memReadQ     <= 1'b0;
      memWriteQ    <= 1'b0;
    end else if (capture) begin
      aluResultOut <= aluResultIn;
      storeDataOut <= storeDataIn;
      rdOut        <= rdIn;
      regWriteQ    <= regWriteIn && (rdIn != '0);
      memReadQ     <= memReadIn && !memWriteIn;
      memWriteQ    <= memWriteIn;
    end
  end

  assign regWriteOut = outValid && regWriteQ;
  assign memReadOut  = outValid && memReadQ;
  assign memWriteOut = outValid && memWriteQ;

`ifdef EX_MEM_BRANCH_EN
  logic            takenNext;
  logic [XLEN-1:0] targetNext;
  logic            takenQ;

  branch_resolve #(
    .XLEN(XLEN)
  ) branchResolver (
    .branch  (branchIn),
    .branchNe(branchNeIn),
    .zero    (zeroIn),
    .pc      (pcIn),
    .imm     (immIn),
    .taken   (takenNext),
    .target  (targetNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      takenQ       <= 1'b0;
      branchTarget <= '0;
    end else if (capture) begin
      takenQ       <= takenNext;
      branchTarget <= targetNext;
    end
  end

  assign branchTaken = outValid && takenQ;
`else
  // Branch inputs have no consumer in this build; the reduction only keeps lint quiet.
  logic unusedBranchInputs;
  assign unusedBranchInputs = ^{branchIn, branchNeIn, zeroIn, pcIn, immIn};

  assign branchTaken  = 1'b0;
  assign branchTarget = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, hand-written
// stall/reset/branch sequences, then randomized traffic against a queue model.
module tb_ex_mem_reg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               inValid, inReady, zeroIn, regWriteIn, memReadIn, memWriteIn;
  logic               branchIn, branchNeIn, flush, outValid, outReady;
  logic               regWriteOut, memReadOut, memWriteOut, branchTaken;
  logic [XLEN-1:0]    aluResultIn, storeDataIn, pcIn, immIn;
  logic [XLEN-1:0]    aluResultOut, storeDataOut, branchTarget;
  logic [RADDR_W-1:0] rdIn, rdOut;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .aluResultIn(aluResultIn), .zeroIn(zeroIn), .storeDataIn(storeDataIn),
    .rdIn(rdIn), .regWriteIn(regWriteIn), .memReadIn(memReadIn),
    .memWriteIn(memWriteIn), .branchIn(branchIn), .branchNeIn(branchNeIn),
    .pcIn(pcIn), .immIn(immIn), .flush(flush), .outValid(outValid),
    .outReady(outReady), .aluResultOut(aluResultOut), .storeDataOut(storeDataOut),
    .rdOut(rdOut), .regWriteOut(regWriteOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .branchTaken(branchTaken), .branchTarget(branchTarget)
  );

  typedef struct {
    logic [31:0] alu, store, pc, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, bne, zero;
  } instr_t;

  typedef struct {
    logic        inValid, outReady, flush;
    instr_t      ins;
    logic        expInReady, expValid;
    logic [31:0] expAlu;
    logic [4:0]  expRd;
    logic        expRw, expMr, expMw;
  } vec_t;

  int     compared   = 0;
  int     mismatched = 0;
  instr_t held[$];
  vec_t   vecs[9];

  function automatic instr_t mkIns(input logic [31:0] alu, input logic [4:0] rd,
                                   input logic rw, input logic mr, input logic mw);
    instr_t i;
    i = '{alu: alu, store: alu ^ 32'hA5A5_0000, pc: 32'h0, imm: 32'h0,
          rd: rd, rw: rw, mr: mr, mw: mw, br: 1'b0, bne: 1'b0, zero: 1'b0};
    return i;
  endfunction

  function automatic vec_t mkVec(input logic v, input logic r, input logic f, input instr_t i,
                                 input logic eir, input logic ev, input logic [31:0] ealu,
                                 input logic [4:0] erd, input logic erw, input logic emr,
                                 input logic emw);
    vec_t t;
    t = '{inValid: v, outReady: r, flush: f, ins: i, expInReady: eir, expValid: ev,
          expAlu: ealu, expRd: erd, expRw: erw, expMr: emr, expMw: emw};
    return t;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic f, input instr_t i);
    inValid     = v;
    outReady    = r;
    flush       = f;
    aluResultIn = i.alu;
    storeDataIn = i.store;
    rdIn        = i.rd;
    regWriteIn  = i.rw;
    memReadIn   = i.mr;
    memWriteIn  = i.mw;
    branchIn    = i.br;
    branchNeIn  = i.bne;
    zeroIn      = i.zero;
    pcIn        = i.pc;
    immIn       = i.imm;
    #1;
  endtask

  // Reference: the stage holds at most one instruction; it leaves when MEM
  // accepts, a new one enters whenever the slot is (or becomes) free.
  task automatic clockEdge();
    if (flush) begin
      held.delete();
    end else begin
      if (outReady && held.size() != 0) void'(held.pop_front());
      if (inValid && held.size() == 0) held.push_back('{alu: aluResultIn, store: storeDataIn,
        pc: pcIn, imm: immIn, rd: rdIn, rw: regWriteIn, mr: memReadIn, mw: memWriteIn,
        br: branchIn, bne: branchNeIn, zero: zeroIn});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    instr_t h;
    logic   v;
    v = (held.size() != 0);
    checkVal({tag, " outValid"}, outValid, v);
    if (v) begin
      h = held[0];
      checkVal({tag, " aluResultOut"}, aluResultOut, h.alu);
      checkVal({tag, " storeDataOut"}, storeDataOut, h.store);
      checkVal({tag, " rdOut"}, rdOut, h.rd);
      checkVal({tag, " regWriteOut"}, regWriteOut, h.rw && (h.rd != 5'd0));
      checkVal({tag, " memReadOut"}, memReadOut, h.mr && !h.mw);
      checkVal({tag, " memWriteOut"}, memWriteOut, h.mw);
`ifdef EX_MEM_BRANCH_EN
      checkVal({tag, " branchTaken"}, branchTaken, h.br && (h.zero != h.bne));
      checkVal({tag, " branchTarget"}, branchTarget, 32'(h.pc + h.imm));
`else
      checkVal({tag, " branchTaken"}, branchTaken, 1'b0);
      checkVal({tag, " branchTarget"}, branchTarget, 32'h0);
`endif
    end else begin
      checkVal({tag, " regWriteOut"}, regWriteOut, 1'b0);
      checkVal({tag, " memReadOut"}, memReadOut, 1'b0);
      checkVal({tag, " memWriteOut"}, memWriteOut, 1'b0);
      checkVal({tag, " branchTaken"}, branchTaken, 1'b0);
    end
  endtask

  initial begin
    instr_t idle, a, b;
    idle = mkIns(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    vecs[0] = mkVec(1, 1, 0, mkIns(32'h1,  5'd5, 1, 0, 0), 1, 1, 32'h1,  5'd5, 1, 0, 0);
    vecs[1] = mkVec(1, 1, 0, mkIns(32'h22, 5'd0, 1, 0, 0), 1, 1, 32'h22, 5'd0, 0, 0, 0);
    vecs[2] = mkVec(1, 1, 0, mkIns(32'h33, 5'd3, 0, 1, 1), 1, 1, 32'h33, 5'd3, 0, 0, 1);
    vecs[3] = mkVec(1, 0, 1, mkIns(32'h44, 5'd4, 0, 0, 1), 0, 0, 32'h0,  5'd0, 0, 0, 0);
    vecs[4] = mkVec(0, 1, 0, idle,                          1, 0, 32'h0,  5'd0, 0, 0, 0);
    vecs[5] = mkVec(1, 0, 0, mkIns(32'h55, 5'd7, 0, 1, 0), 1, 1, 32'h55, 5'd7, 0, 1, 0);
    vecs[6] = mkVec(0, 1, 0, idle,                          1, 0, 32'h0,  5'd0, 0, 0, 0);
    vecs[7] = mkVec(1, 1, 0, mkIns(32'h66, 5'd8, 1, 0, 1), 1, 1, 32'h66, 5'd8, 1, 0, 1);
    vecs[8] = mkVec(1, 1, 0, mkIns(32'h77, 5'd9, 1, 0, 0), 1, 1, 32'h77, 5'd9, 1, 0, 0);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, idle);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    checkVal("reset aluResultOut", aluResultOut, 32'h0);
    checkVal("reset rdOut", rdOut, 5'd0);
    checkVal("reset inReady", inReady, 1'b1);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].inValid, vecs[k].outReady, vecs[k].flush, vecs[k].ins);
      checkVal($sformatf("vec%0d inReady", k), inReady, vecs[k].expInReady);
      clockEdge();
      checkVal($sformatf("vec%0d outValid", k), outValid, vecs[k].expValid);
      checkVal($sformatf("vec%0d regWriteOut", k), regWriteOut, vecs[k].expRw);
      checkVal($sformatf("vec%0d memReadOut", k), memReadOut, vecs[k].expMr);
      checkVal($sformatf("vec%0d memWriteOut", k), memWriteOut, vecs[k].expMw);
      if (vecs[k].expValid) begin
        checkVal($sformatf("vec%0d aluResultOut", k), aluResultOut, vecs[k].expAlu);
        checkVal($sformatf("vec%0d rdOut", k), rdOut, vecs[k].expRd);
      end
    end

    // Stall for three cycles with a new instruction waiting, then release.
    a = mkIns(32'hA1, 5'd9, 1, 0, 0);
    b = mkIns(32'hB2, 5'd10, 1, 0, 0);
    applyStimulus(1, 1, 0, a);
    clockEdge();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, b);
      checkVal("stall inReady", inReady, 1'b0);
      clockEdge();
      checkVal("stall aluResultOut", aluResultOut, 32'hA1);
      checkVal("stall rdOut", rdOut, 5'd9);
      checkVal("stall outValid", outValid, 1'b1);
    end
    applyStimulus(1, 1, 0, b);
    checkVal("release inReady", inReady, 1'b1);
    clockEdge();
    checkVal("release aluResultOut", aluResultOut, 32'hB2);
    checkVal("release outValid", outValid, 1'b1);

`ifdef EX_MEM_BRANCH_EN
    a = mkIns(32'h0, 5'd0, 0, 0, 0);
    a.br = 1'b1; a.bne = 1'b0; a.zero = 1'b1; a.pc = 32'hFFFF_FFFC; a.imm = 32'h8;
    applyStimulus(1, 1, 0, a);
    clockEdge();
    checkVal("beq branchTaken", branchTaken, 1'b1);
    checkVal("beq branchTarget", branchTarget, 32'h0000_0004);
    a.bne = 1'b1;
    applyStimulus(1, 1, 0, a);
    clockEdge();
    checkVal("bne branchTaken", branchTaken, 1'b0);
`else
    a = mkIns(32'h0, 5'd0, 0, 0, 0);
    a.br = 1'b1; a.zero = 1'b1; a.pc = 32'hFFFF_FFFC; a.imm = 32'h8;
    applyStimulus(1, 1, 0, a);
    clockEdge();
    checkVal("nobranch branchTaken", branchTaken, 1'b0);
    checkVal("nobranch branchTarget", branchTarget, 32'h0);
`endif

    // Reset asserted mid-stall must clear everything without a clock edge.
    a = mkIns(32'hC3, 5'd12, 1, 0, 1);
    applyStimulus(1, 1, 0, a);
    clockEdge();
    applyStimulus(1, 0, 0, b);
    clockEdge();
    checkVal("prereset outValid", outValid, 1'b1);
    rst_n = 1'b0;
    held.delete();
    #1;
    checkVal("asyncrst outValid", outValid, 1'b0);
    checkVal("asyncrst aluResultOut", aluResultOut, 32'h0);
    checkVal("asyncrst storeDataOut", storeDataOut, 32'h0);
    checkVal("asyncrst rdOut", rdOut, 5'd0);
    checkVal("asyncrst regWriteOut", regWriteOut, 1'b0);
    checkVal("asyncrst memWriteOut", memWriteOut, 1'b0);
    checkVal("asyncrst branchTaken", branchTaken, 1'b0);
    checkVal("asyncrst branchTarget", branchTarget, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, b);
    clockEdge();
    checkOutput("postreset");

    for (int k = 0; k < 400; k++) begin
      instr_t r;
      logic   v, rdy, f;
      r.alu   = $urandom;
      r.store = $urandom;
      r.pc    = $urandom;
      r.imm   = $urandom;
      r.rd    = 5'($urandom_range(0, 31));
      r.rw    = 1'($urandom);
      r.mr    = 1'($urandom);
      r.mw    = 1'($urandom);
      r.br    = 1'($urandom);
      r.bne   = 1'($urandom);
      r.zero  = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 15) == 0);
      applyStimulus(v, rdy, f, r);
      checkVal("rand inReady", inReady, (held.size() == 0) || rdy);
      clockEdge();
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
